// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving two requesters access to one single-port RAM.
// Define RAM_ARB_CLEAR_EN to compile in a CLEAR sweep that zeroes the RAM after reset.
module ram_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_ram_in,
  output logic              o_ram_load,
  output logic [ADDR_W-1:0] o_ram_address,
  input  logic [DATA_W-1:0] i_ram_out
);

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t              r_state;
  state_t              w_next;
  logic                r_grant;
  logic                r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_winner;
  logic                w_any_req;

  // On contention the port that did not win last time is served.
  assign w_any_req = i_req0 | i_req1;
  assign w_winner  = (i_req0 && i_req1) ? ~r_last : i_req1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
`ifdef RAM_ARB_CLEAR_EN
      CLEAR:   if (r_addr == {ADDR_W{1'b1}}) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // r_addr doubles as the CLEAR word counter, so the RAM port keeps its last address afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RESET_STATE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_winner;
            r_we    <= w_winner ? i_we1 : i_we0;
            r_addr  <= w_winner ? i_addr1 : i_addr0;
            r_wdata <= w_winner ? i_wdata1 : i_wdata0;
          end
        end
        ACCESS:  r_rdata <= r_we ? r_wdata : i_ram_out;
        DONE:    r_last <= r_grant;
`ifdef RAM_ARB_CLEAR_EN
        CLEAR:   if (r_addr != {ADDR_W{1'b1}}) r_addr <= r_addr + ADDR_W'(1);
`endif
        default: ;
      endcase
    end
  end

`ifdef RAM_ARB_CLEAR_EN
  assign o_ram_load = ((r_state == ACCESS) && r_we) || ((r_state == CLEAR) && !i_rst);
`else
  assign o_ram_load = (r_state == ACCESS) && r_we;
`endif

  assign o_ram_address = r_addr;
  assign o_ram_in      = r_wdata;
  assign o_rdata       = r_rdata;
  assign o_busy        = (r_state != IDLE);
  assign o_ack0        = (r_state == DONE) && !r_grant;
  assign o_ack1        = (r_state == DONE) && r_grant;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural RAM and reference model.
// Covers both builds; the CLEAR sweep checks compile only when RAM_ARB_CLEAR_EN is defined.
module tb_ram_arbiter;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, ramLoad;
  logic [DW-1:0] rdata, ramIn, ramOut;
  logic [AW-1:0] ramAddress;

  logic [DW-1:0] ramMem [8];
  logic [DW-1:0] refMem [8];
  int            refLast;
  int            errors;
  int            checks;

  typedef struct {
    bit            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expData;
  } vec_t;

  vec_t vecs[$];

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_busy(busy),
    .o_ram_in(ramIn), .o_ram_load(ramLoad), .o_ram_address(ramAddress),
    .i_ram_out(ramOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple single-port RAM with combinational read, as the arbiter expects.
  always @(posedge clk) if (ramLoad) ramMem[ramAddress] <= ramIn;
  assign ramOut = ramMem[ramAddress];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One round of requests; called just after a rising edge with the arbiter idle.
  task automatic applyStimulus(input bit r0, input bit r1, input logic w0, input logic w1,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               output logic [DW-1:0] lastData, output int firstPort);
    int            order[2];
    int            n;
    int            p;
    logic          wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] dt;
    logic [DW-1:0] exp;
    if (r0 && r1) begin
      order[0] = (refLast == 1) ? 0 : 1;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = r1 ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    firstPort = order[0];
    lastData  = '0;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    for (int k = 0; k < n; k++) begin
      p  = order[k];
      wr = (p == 1) ? w1 : w0;
      ad = (p == 1) ? a1 : a0;
      dt = (p == 1) ? d1 : d0;
      if (wr) begin
        exp = dt;
        refMem[ad] = dt;
      end else begin
        exp = refMem[ad];
      end
      refLast = p;
      @(negedge clk);
      checkOutput("idle busy", busy, 0);
      checkOutput("idle ack", {ack1, ack0}, 0);
      @(negedge clk);
      checkOutput("access busy", busy, 1);
      checkOutput("access ack", {ack1, ack0}, 0);
      checkOutput("access load", ramLoad, wr);
      checkOutput("access addr", ramAddress, ad);
      @(negedge clk);
      checkOutput("done ack", {ack1, ack0}, (p == 1) ? 2 : 1);
      checkOutput("done rdata", rdata, exp);
      checkOutput("done busy", busy, 1);
      checkOutput("done load", ramLoad, 0);
      lastData = rdata;
      @(posedge clk);
      #1;
      if (p == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
  endtask

`ifdef RAM_ARB_CLEAR_EN
  // Called on the falling edge where reset is released; follows the zeroing sweep.
  task automatic waitClear(input bit raiseReq);
    int cnt;
    cnt = 0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      checkOutput("clear load", ramLoad, 1);
      checkOutput("clear addr", ramAddress, cnt);
      checkOutput("clear in", ramIn, 0);
      cnt++;
      if (raiseReq && cnt == 3) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd7;
      end
      @(negedge clk);
      #1;
    end
    checkOutput("clear length", cnt, 8);
    for (int a = 0; a < 8; a++) refMem[a] = '0;
    refLast = 1;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [DW-1:0] rd;
    int            fp;
    bit            rr0, rr1, rw0, rw1;

    errors = 0;
    checks = 0;
    refLast = 1;
    for (int a = 0; a < 8; a++) refMem[a] = '0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

    vecs.push_back('{1'b0, 1'b1, 3'd5, 16'h1234, 16'h1234});
    vecs.push_back('{1'b1, 1'b0, 3'd5, 16'h0000, 16'h1234});
    for (int a = 0; a < 8; a++) vecs.push_back('{a[0], 1'b1, 3'(a), 16'(a), 16'(a)});
    for (int a = 0; a < 8; a++) vecs.push_back('{a[0], 1'b0, 3'(a), 16'h0000, 16'(a)});

    rst = 1'b1;
    #1;
    checkOutput("reset acks", {ack1, ack0}, 0);
    checkOutput("reset load", ramLoad, 0);
    checkOutput("reset rdata", rdata, 0);
    checkOutput("reset addr", ramAddress, 0);
    checkOutput("reset ram_in", ramIn, 0);
`ifdef RAM_ARB_CLEAR_EN
    checkOutput("reset busy", busy, 1);
`else
    checkOutput("reset busy", busy, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
    waitClear(1'b0);
`endif
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].port == 0, vecs[i].port == 1, vecs[i].we, vecs[i].we,
                    vecs[i].addr, vecs[i].addr, vecs[i].wdata, vecs[i].wdata, rd, fp);
      checkOutput("table rdata", rd, vecs[i].expData);
    end

    $display("[TB] contention");
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd6, 16'h0, 16'h0, rd, fp);
      checkOutput("contention first port", fp, 0);
      checkOutput("contention last rdata", rd, 16'd6);
    end

    $display("[TB] reset during access");
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd2; wdata0 = 16'hFFFF;
    @(posedge clk);
    #2;
    checkOutput("pre-reset access load", ramLoad, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid reset load", ramLoad, 0);
    checkOutput("mid reset acks", {ack1, ack0}, 0);
    checkOutput("mid reset rdata", rdata, 0);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    refLast = 1;
`ifdef RAM_ARB_CLEAR_EN
    waitClear(1'b0);
`else
    #1;
    checkOutput("post reset busy", busy, 0);
`endif
    @(posedge clk);
    #1;
    checkOutput("post reset acks", {ack1, ack0}, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 16'h0, 16'h0, rd, fp);
`ifdef RAM_ARB_CLEAR_EN
    checkOutput("lost write addr2", rd, 16'h0000);
`else
    checkOutput("lost write addr2", rd, 16'd2);
`endif

`ifdef RAM_ARB_CLEAR_EN
    $display("[TB] clear sweep");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 16'hAAAA, 16'h0, rd, fp);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitClear(1'b1);
    @(negedge clk);
    checkOutput("clear req access ack", {ack1, ack0}, 0);
    checkOutput("clear req access busy", busy, 1);
    @(negedge clk);
    checkOutput("clear req ack", {ack1, ack0}, 1);
    checkOutput("clear req rdata", rdata, 16'h0000);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    refLast = 0;
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      rr0 = 1'($urandom_range(0, 1));
      rr1 = 1'($urandom_range(0, 1));
      if (!rr0 && !rr1) rr0 = 1'b1;
      rw0 = 1'($urandom_range(0, 1));
      rw1 = 1'($urandom_range(0, 1));
      applyStimulus(rr0, rr1, rw0, rw1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    16'($urandom), 16'($urandom), rd, fp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 3, RAM address width (8 words).
REQ-002 Parameter: DATA_W, default 16, RAM word width.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  requester 0 access request, held high until ack0.
REQ-006 we0  input  1  requester 0 write (1) or read (0).
REQ-007 addr0  input  ADDR_W  requester 0 word address.
REQ-008 wdata0  input  DATA_W  requester 0 write data.
REQ-009 req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  requester 1, same meaning as requester 0.
REQ-010 ack0, ack1  output  1  one-cycle completion pulse per requester.
REQ-011 rdata  output  DATA_W  read result, valid in the ack cycle.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 ram_in  output  DATA_W  drives RAM in.
REQ-014 ram_load  output  1  drives RAM load.
REQ-015 ram_address  output  ADDR_W  drives RAM address.
REQ-016 ram_out  input  DATA_W  RAM out, combinational from ram_address.

Function
REQ-017 States: IDLE, ACCESS, DONE, plus CLEAR when RAM_ARB_CLEAR_EN is defined.
REQ-018 IDLE: no req -> stay in IDLE; any req -> select a winner, latch its we/addr/wdata and grant id, then go to ACCESS.
REQ-019 Single request: the requesting port wins.
REQ-020 Both requesting: the port not granted most recently wins (round-robin); after reset, last-grant = 1, so port 0 wins first.
REQ-021 ACCESS, one cycle: ram_address = latched addr, ram_in = latched wdata, ram_load = latched we.
REQ-022 At the edge ending ACCESS: the RAM performs any write, rdata captures ram_out, and the state goes to DONE.
REQ-023 DONE, one cycle: ack of the granted port = 1; last-grant updates to that port; next state is IDLE.
REQ-024 Write access: rdata holds the value written (RAM write-through read).
REQ-025 Latency: req seen in IDLE -> ack exactly 2 cycles later; back-to-back accesses every 3 cycles.
REQ-026 Requester deasserts req at the edge where it registers ack; a req still high in IDLE is a new request.
REQ-027 In IDLE and DONE: ram_load = 0; ram_address and ram_in hold their last driven values.
REQ-028 Request inputs that change during ACCESS or DONE have no effect on the access in progress.
REQ-029 ack0 and ack1 are never high in the same cycle.
REQ-030 rdata holds its value until the next capture.

Reset
REQ-031 On reset assertion, immediately: ack0 = ack1 = 0, ram_load = 0, rdata = 0, ram_address = 0, ram_in = 0, last-grant = 1.
REQ-032 State after reset: IDLE (busy = 0), or CLEAR when RAM_ARB_CLEAR_EN is defined.
REQ-033 Reset asserted during ACCESS: no write occurs, no ack is issued, and the request is lost; the requester must re-request.

Configuration
REQ-034 Macro RAM_ARB_CLEAR_EN; when defined, the CLEAR state is compiled in.
REQ-035 CLEAR: a counter runs 0 to 2^ADDR_W-1, one word per cycle; each cycle ram_load = 1, ram_in = 0, ram_address = counter, busy = 1.
REQ-036 CLEAR exit: after the last word the state goes to IDLE; requests raised during CLEAR are held pending and serviced from IDLE.
REQ-037 Undefined: no CLEAR state and no counter; RAM contents after reset are unspecified by this block.

Verification
REQ-038 Write/read: req0 write addr 5 data 16'h1234, then req1 read addr 5 -> ack0 2 cycles after req0, then ack1 with rdata = 16'h1234.
REQ-039 Contention: req0 and req1 raised in the same cycle after reset, both reads -> ack0 first, then ack1 3 cycles later; repeat -> ack0 first again, because last-grant = 1 after the second access.
REQ-040 Fill and check: write data = address for all 8 addresses, alternating ports, then read back all 8 -> each rdata equals its address; busy low only in IDLE.
REQ-041 Reset in ACCESS: req0 write addr 2 data 16'hFFFF with reset asserted mid-ACCESS -> no ack, ram_load falls immediately, later read of addr 2 returns its prior value.
REQ-042 With RAM_ARB_CLEAR_EN: write 16'hAAAA to addr 7, pulse reset -> busy high 8 cycles with ram_load = 1, then a read of addr 7 returns 16'h0000; a req0 raised during CLEAR is acked 2 cycles after CLEAR ends.
